inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage feeding the decode stage. Holds the PC, reads each 32-bit instruction from a byte-wide instruction memory port as four little-endian byte requests, and presents `{pc, inst}` to decode over a valid/ready handshake. It accepts redirects (`branch_flag`/`branch_addr`) produced by decode, discarding any partially or fully fetched instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be 4-aligned.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_req_o`  out  1  byte read request to instruction memory.
- `mem_addr_o`  out  32  byte address of the current request.
- `mem_ack_i`  in  1  memory has returned the byte for `mem_addr_o` this cycle.
- `mem_data_i`  in  8  returned byte; valid only when `mem_ack_i` is high.
- `inst_valid_o`  out  1  `pc_o`/`inst_o` hold a complete instruction.
- `id_ready_i`  in  1  decode accepts the instruction this cycle.
- `pc_o`  out  32  address of the presented instruction.
- `inst_o`  out  32  presented instruction word.
- `branch_flag_i`  in  1  redirect request from decode (single-cycle pulse).
- `branch_addr_i`  in  32  redirect target; bits [1:0] are ignored and treated as 00.

## Operation
- Internal state: `pc` (32), `byte_idx` (2), `inst_buf` (32), FSM {FETCH, HOLD}.
- FETCH: `mem_req_o`=1, `mem_addr_o`=`pc`+`byte_idx`. On `mem_ack_i`:
  - `inst_buf[8k+7:8k]` <= `mem_data_i`, with k=`byte_idx`.
  - If k<3: `byte_idx`++.
  - If k==3: `inst_o` <= {`mem_data_i`, `inst_buf[23:0]`}, `pc_o` <= `pc`, `inst_valid_o` <= 1, `byte_idx` <= 0, go to HOLD.
  - Without `mem_ack_i`: address and request are held unchanged.
- HOLD: `mem_req_o`=0; `pc_o`/`inst_o` stable. On `id_ready_i`: `inst_valid_o` <= 0, `pc` <= `pc`+4 (mod 2^32), go to FETCH.
- Redirect: `branch_flag_i`=1 has priority over every other event in both states.
  - Next cycle: `pc` <= {`branch_addr_i[31:2]`, 2'b00}, `byte_idx` <= 0, `inst_valid_o` <= 0, state FETCH.
  - Bytes already buffered, a same-cycle ack, and any held instruction are discarded.
- Boundary cases:
  - Branch and `id_ready_i` in the same cycle: the handshake counts as a transfer; the next fetch uses the branch target, not pc+4.
  - Branch and the final-byte `mem_ack_i` in the same cycle: no valid is raised.
  - PC wraps from 0xFFFF_FFFC to 0x0000_0000.
- Reset, including mid-fetch: `pc`=`RESET_PC`, `byte_idx`=0, state FETCH, `inst_buf`=0.
- Output reset values:
  - `mem_req_o`=0, `mem_addr_o`=`RESET_PC`.
  - `inst_valid_o`=0, `pc_o`=`RESET_PC`, `inst_o`=0.
  - Request resumes the cycle after `rst` deasserts.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- With `mem_ack_i` tied high, starting at FETCH cycle t0 with `byte_idx`=0:
  - Acks occur in cycles t0..t0+3.
  - `inst_valid_o` is high from t0+4.
  - If `id_ready_i` is high at t0+4, the next request (pc+4, byte 0) issues at t0+5.
  - Peak throughput: one instruction per 5 cycles.
- Redirect asserted in cycle t: `mem_addr_o`=target at t+1 with `mem_req_o`=1.
- `mem_addr_o` changes only on the cycle after an ack, a redirect, or reset.

## Structure
- Shared defines header: `InstAddrBus`, `InstBus`, `ZeroWord`, and the default `RESET_PC` constant. FSM state encodings are local to this block.
- Single module; no sub-module is warranted. Byte assembly is an indexed register write.

## Test plan
- Reset with `RESET_PC`=0; memory bytes 0x13,0x05,0x10,0x00 at 0..3; ack every cycle.
  - Required: `mem_addr_o` sequence 0,1,2,3.
  - Required: `inst_o`=0x0010_0513, `pc_o`=0, `inst_valid_o` high 4 cycles after the first request.
- Same program with ack every other cycle.
  - Required: each address held for 2 cycles; identical `inst_o`.
  - Required: valid rises 1 cycle after the 4th ack.
- `id_ready_i` low for 3 cycles in HOLD.
  - Required: `inst_o`/`pc_o` stable and `mem_req_o`=0 throughout.
  - Required: after accept, next `mem_addr_o`=4.
- `branch_flag_i` with `branch_addr_i`=0x100 during byte 2 of the fetch at 0.
  - Required: no valid for pc 0; next `mem_addr_o`=0x100.
  - Required: then `pc_o`=0x100 with the bytes at 0x100..0x103.
- In HOLD, `id_ready_i` and `branch_flag_i` (addr 0x102) in the same cycle.
  - Required: next request at 0x100; no fetch of pc+4.
- `rst` pulsed during byte 1 of a fetch at 0x40.
  - Required: all outputs return to reset values the next cycle.
  - Required: fetch restarts at `RESET_PC` byte 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared bus widths and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord       = 32'h0000_0000;
  localparam logic [InstAddrBus-1:0] DefaultResetPc = 32'h0000_0000;

  // Word-align an address by clearing its two byte-offset bits.
  function automatic logic [InstAddrBus-1:0] align4(input logic [InstAddrBus-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Fetch stage: assembles 32-bit instructions from four byte reads and hands
// {pc, inst} to decode over valid/ready; redirects from decode win over everything.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = DefaultResetPc
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [7:0]             mem_data_i,
  output logic                   inst_valid_o,
  input  logic                   id_ready_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_addr_i
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e                 state_reg,    state_next;
  logic [InstAddrBus-1:0] pc_reg,       pc_next;
  logic [1:0]             byte_idx_reg, byte_idx_next;
  logic [InstBus-1:0]     inst_buf_reg, inst_buf_next;
  logic                   req_reg,      req_next;
  logic [InstAddrBus-1:0] addr_reg,     addr_next;
  logic                   valid_reg,    valid_next;
  logic [InstAddrBus-1:0] pc_out_reg,   pc_out_next;
  logic [InstBus-1:0]     inst_reg,     inst_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      byte_idx_reg <= 2'd0;
      inst_buf_reg <= ZeroWord;
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
      valid_reg    <= 1'b0;
      pc_out_reg   <= RESET_PC;
      inst_reg     <= ZeroWord;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      byte_idx_reg <= byte_idx_next;
      inst_buf_reg <= inst_buf_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      valid_reg    <= valid_next;
      pc_out_reg   <= pc_out_next;
      inst_reg     <= inst_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    byte_idx_next = byte_idx_reg;
    inst_buf_next = inst_buf_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    valid_next    = valid_reg;
    pc_out_next   = pc_out_reg;
    inst_next     = inst_reg;

    if (branch_flag_i) begin
      state_next    = FETCH;
      pc_next       = align4(branch_addr_i);
      byte_idx_next = 2'd0;
      req_next      = 1'b1;
      addr_next     = align4(branch_addr_i);
      valid_next    = 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          // The first cycle after reset has no request outstanding yet, so
          // any ack seen then cannot belong to us.
          if (!req_reg) begin
            req_next = 1'b1;
          end else if (mem_ack_i) begin
            inst_buf_next[{byte_idx_reg, 3'b000} +: 8] = mem_data_i;
            if (byte_idx_reg != 2'd3) begin
              byte_idx_next = byte_idx_reg + 2'd1;
              addr_next     = {pc_reg[InstAddrBus-1:2], byte_idx_reg + 2'd1};
            end else begin
              inst_next     = {mem_data_i, inst_buf_reg[23:0]};
              pc_out_next   = pc_reg;
              valid_next    = 1'b1;
              byte_idx_next = 2'd0;
              req_next      = 1'b0;
              // Pre-load the sequential address so it is ready the moment decode accepts.
              addr_next     = pc_reg + 32'd4;
              state_next    = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_ready_i) begin
            valid_next = 1'b0;
            pc_next    = pc_reg + 32'd4;
            req_next   = 1'b1;
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign mem_req_o    = req_reg;
  assign mem_addr_o   = addr_reg;
  assign inst_valid_o = valid_reg;
  assign pc_o         = pc_out_reg;
  assign inst_o       = inst_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized checks of inst_fetch against a transaction-level
// model of the fetch stream (expected pc, bytes collected so far).
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        inst_valid_o;
  logic        id_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .inst_valid_o (inst_valid_o),
    .id_ready_i   (id_ready_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a small program at 0, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C ^ {6'd0, a[1:0]};
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch bytes lo..hi of the word at base, waiting `gap` idle cycles before each ack.
  task automatic fetch_bytes(input logic [31:0] base, input int lo, input int hi, input int gap);
    for (int k = lo; k <= hi; k++) begin
      for (int g = 0; g < gap; g++) begin
        check("wait_req", {31'd0, mem_req_o}, 32'd1);
        check("wait_addr", mem_addr_o, base + k);
        check("wait_valid", {31'd0, inst_valid_o}, 32'd0);
        mem_ack_i = 1'b0;
        step();
      end
      check("req", {31'd0, mem_req_o}, 32'd1);
      check("addr", mem_addr_o, base + k);
      mem_ack_i  = 1'b1;
      mem_data_i = mem_byte(mem_addr_o);
      step();
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic expect_hold(input logic [31:0] pc);
    check("hold_valid", {31'd0, inst_valid_o}, 32'd1);
    check("hold_req", {31'd0, mem_req_o}, 32'd0);
    check("hold_pc", pc_o, pc);
    check("hold_inst", inst_o, mem_word(pc));
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          nb;
    logic        br, rdy, ack;
    logic [31:0] tgt;

    rst = 1'b1; mem_ack_i = 1'b0; mem_data_i = 8'h00; id_ready_i = 1'b0;
    branch_flag_i = 1'b0; branch_addr_i = 32'h0;
    step(); step();
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    rst = 1'b0;
    step();

    // Back-to-back acks: valid four cycles after the first request.
    fetch_bytes(32'h0, 0, 3, 0);
    check("prog_inst", inst_o, 32'h0010_0513);
    expect_hold(32'h0);

    // Decode stalls three cycles; output must not move.
    for (int i = 0; i < 3; i++) begin
      step();
      expect_hold(32'h0);
    end
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    check("accept_valid", {31'd0, inst_valid_o}, 32'd0);
    check("accept_req", {31'd0, mem_req_o}, 32'd1);
    check("accept_addr", mem_addr_o, 32'h4);

    // Redirect back to 0, then ack every other cycle.
    branch_flag_i = 1'b1; branch_addr_i = 32'h0;
    step();
    branch_flag_i = 1'b0;
    fetch_bytes(32'h0, 0, 3, 1);
    check("slow_inst", inst_o, 32'h0010_0513);
    expect_hold(32'h0);
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;

    // Redirect to 0x100 coinciding with the ack of byte 2 of the fetch at 0.
    branch_flag_i = 1'b1; branch_addr_i = 32'h0;
    step();
    branch_flag_i = 1'b0;
    fetch_bytes(32'h0, 0, 1, 0);
    check("br_mid_addr", mem_addr_o, 32'h2);
    mem_ack_i = 1'b1; mem_data_i = mem_byte(32'h2);
    branch_flag_i = 1'b1; branch_addr_i = 32'h100;
    step();
    mem_ack_i = 1'b0; branch_flag_i = 1'b0;
    check("br_mid_valid", {31'd0, inst_valid_o}, 32'd0);
    check("br_mid_req", {31'd0, mem_req_o}, 32'd1);
    check("br_mid_target", mem_addr_o, 32'h100);
    fetch_bytes(32'h100, 0, 3, 0);
    expect_hold(32'h100);

    // Accept and redirect to 0x102 together: target wins, low bits dropped.
    id_ready_i = 1'b1; branch_flag_i = 1'b1; branch_addr_i = 32'h102;
    step();
    id_ready_i = 1'b0; branch_flag_i = 1'b0;
    check("br_hold_valid", {31'd0, inst_valid_o}, 32'd0);
    check("br_hold_addr", mem_addr_o, 32'h100);
    fetch_bytes(32'h100, 0, 3, 0);
    expect_hold(32'h100);

    // Last-byte ack together with a redirect raises no valid.
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    fetch_bytes(32'h104, 0, 2, 0);
    mem_ack_i = 1'b1; mem_data_i = mem_byte(32'h107);
    branch_flag_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC;
    step();
    mem_ack_i = 1'b0; branch_flag_i = 1'b0;
    check("br_last_valid", {31'd0, inst_valid_o}, 32'd0);
    check("br_last_addr", mem_addr_o, 32'hFFFF_FFFC);

    // PC wrap from the top of the address space.
    fetch_bytes(32'hFFFF_FFFC, 0, 3, 0);
    expect_hold(32'hFFFF_FFFC);
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    check("wrap_addr", mem_addr_o, 32'h0);

    // Reset during byte 1 of a fetch at 0x40.
    branch_flag_i = 1'b1; branch_addr_i = 32'h40;
    step();
    branch_flag_i = 1'b0;
    fetch_bytes(32'h40, 0, 0, 0);
    check("mid_rst_addr", mem_addr_o, 32'h41);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    check("mid_rst_addr0", mem_addr_o, 32'h0);
    check("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_inst", inst_o, 32'h0);
    step();
    fetch_bytes(32'h0, 0, 3, 0);
    expect_hold(32'h0);

    // Randomized traffic against the stream model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    exp_pc = 32'h0;
    nb     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_valid", {31'd0, inst_valid_o}, {31'd0, nb == 4});
      check("rnd_req", {31'd0, mem_req_o}, {31'd0, nb < 4});
      if (nb < 4) begin
        check("rnd_addr", mem_addr_o, exp_pc + nb);
      end else begin
        check("rnd_pc", pc_o, exp_pc);
        check("rnd_inst", inst_o, mem_word(exp_pc));
      end
      br  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      ack = (nb < 4) && ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      branch_flag_i = br;
      branch_addr_i = tgt;
      id_ready_i    = rdy;
      mem_ack_i     = ack;
      mem_data_i    = mem_byte(mem_addr_o);
      step();
      if (br) begin
        exp_pc = tgt & ~32'h3;
        nb     = 0;
      end else if (nb == 4 && rdy) begin
        exp_pc = exp_pc + 32'd4;
        nb     = 0;
      end else if (ack) begin
        nb++;
      end
    end
    branch_flag_i = 1'b0; id_ready_i = 1'b0; mem_ack_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
